// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, default sizing, clock rate.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
  localparam int          DEF_CNT_W       = 26;

endpackage

// File: rtl/freq_meter_if.sv
// Request/result bus of the frequency meter. FREQ_METER_OVF_EN adds the ovf flag.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] result;

`ifdef FREQ_METER_OVF_EN
  logic             ovf;

  modport master (output start, input busy, valid, result, ovf);
  modport slave  (input start, output busy, valid, result, ovf);
`else
  modport master (output start, input busy, valid, result);
  modport slave  (input start, output busy, valid, result);
`endif

endinterface

// File: rtl/freq_meter_sync_rise.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_rise (
  input  logic clk,
  input  logic rstn,
  input  logic sig_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  // NOTE: flops are written with <= so every stage samples the pre-edge value of its source.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES window per request.
// Build option FREQ_METER_OVF_EN adds a saturation flag reported alongside the result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int          CNT_W       = DEF_CNT_W
) (
  input logic         clk,
  input logic         rstn,
  input logic         sig_in,
  freq_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_inc;
  logic [CNT_W-1:0] result_q;
  logic             rise;
  logic             last;
  logic             cnt_full;
  logic             busy;
  logic             valid;

  sync_rise u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign last     = (gate_cnt == GATE_LAST);
  assign cnt_full = (edge_cnt == CNT_MAX);
  // Saturating increment; this value also feeds the result so a rise in the final cycle counts.
  assign edge_inc = (rise && !cnt_full) ? edge_cnt + CNT_W'(1) : edge_cnt;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = ARM;
      end
      ARM: begin
        busy     = 1'b1;
        state_nx = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + 32'd1;
          edge_cnt <= edge_inc;
          if (last) result_q <= edge_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef FREQ_METER_OVF_EN
  logic ovf_flag;
  logic ovf_q;
  logic ovf_hit;

  // A rise that finds the counter already full is the one that got lost.
  assign ovf_hit = rise & cnt_full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_flag <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ARM: ovf_flag <= 1'b0;
        MEASURE: begin
          ovf_flag <= ovf_flag | ovf_hit;
          if (last) ovf_q <= ovf_flag | ovf_hit;
        end
        default: ;
      endcase
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy   = busy;
  assign bus.valid  = valid;
  assign bus.result = result_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized self-checking bench for freq_meter; an edge-log model predicts every result.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int W    = 8;
  localparam int WS   = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic sig_in = 1'b0;

  freq_meter_if #(.CNT_W(W))  bus_m ();
  freq_meter_if #(.CNT_W(WS)) bus_s ();

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sig_in (sig_in),
    .bus    (bus_m)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(WS)) dut_sat (
    .clk    (clk),
    .rstn   (rstn),
    .sig_in (sig_in),
    .bus    (bus_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests_run    = 0;
  int tests_failed = 0;

  // Signal generator: 0 = hold level, 1 = square wave of 2*half cycles, 2 = random level per cycle.
  int   gen_mode = 1;
  int   half     = 1;
  int   phase    = 0;
  logic hold_val = 1'b0;
  int   rise_q[$];

  always @(negedge clk) begin : gen
    logic nv;
    case (gen_mode)
      0:       nv = hold_val;
      1:       nv = ((phase % (2 * half)) < half);
      default: nv = 1'($urandom_range(0, 1));
    endcase
    phase++;
    if (nv && !sig_in) rise_q.push_back(cyc);
    sig_in = nv;
  end

  // The meter sees an edge three clocks late, so a start launched at negedge c0 covers the
  // sig_in edges launched at negedges c0 .. c0+GATE-1.
  function automatic int model_count(input int c0);
    int n = 0;
    foreach (rise_q[k])
      if (rise_q[k] >= c0 && rise_q[k] <= c0 + GATE - 1) n++;
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic set_start(input bit s, input logic v);
    if (s) bus_s.start = v;
    else   bus_m.start = v;
  endtask

  // One measurement: start at negedge c0, then observe 110 negedges.
  task automatic run_window(input bit s, input bit extra, output int c0, output int valid_n,
                            output int valid_i, output int busy_bad, output logic [7:0] res,
                            output logic ovf_o);
    logic b, v;
    @(negedge clk);
    c0 = cyc;
    set_start(s, 1'b1);
    valid_n = 0; valid_i = -1; busy_bad = 0; res = '0; ovf_o = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      set_start(s, extra && (i == 1 || i == 50 || i == 101));
      b = s ? bus_s.busy  : bus_m.busy;
      v = s ? bus_s.valid : bus_m.valid;
      if (b !== (i <= 101)) busy_bad++;
      if (v === 1'b1) begin
        valid_n++;
        valid_i = i;
        res = s ? 8'(bus_s.result) : bus_m.result;
`ifdef FREQ_METER_OVF_EN
        ovf_o = s ? bus_s.ovf : bus_m.ovf;
`endif
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    gen_mode = 1; half = 1;
    bus_m.start = 1'b1;
    bus_s.start = 1'b1;
    rstn = 1'b0;
    settle(3);
    tests_run++;
    if (bus_m.busy !== 1'b0 || bus_m.valid !== 1'b0 || bus_m.result !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b valid=%b result=%0d, expected 0 0 0",
               bus_m.busy, bus_m.valid, bus_m.result);
    end
    tests_run++;
    if (bus_s.busy !== 1'b0 || bus_s.valid !== 1'b0 || bus_s.result !== '0) begin
      tests_failed++;
      $display("FAIL reset_state_sat: busy=%b valid=%b result=%0d, expected 0 0 0",
               bus_s.busy, bus_s.valid, bus_s.result);
    end
    rstn = 1'b1;
    bus_m.start = 1'b0;
    bus_s.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus_m.busy !== 1'b0 || bus_m.valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL start_during_reset cycle %0d: busy=%b valid=%b, expected 0 0",
                 i, bus_m.busy, bus_m.valid);
      end
    end
  endtask

  task automatic test_idle_zero;
    int c0, vn, vi, bb; logic [7:0] res; logic ov;
    gen_mode = 0; hold_val = 1'b0;
    settle(5);
    run_window(1'b0, 1'b0, c0, vn, vi, bb, res, ov);
    tests_run++;
    if (bb !== 0) begin
      tests_failed++;
      $display("FAIL idle_busy: %0d cycles with wrong busy, expected 0", bb);
    end
    tests_run++;
    if (vn !== 1 || vi !== 102) begin
      tests_failed++;
      $display("FAIL idle_valid: %0d pulses, last at +%0d, expected 1 at +102", vn, vi);
    end
    tests_run++;
    if (res !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_result: got %0d expected 0", res);
    end
  endtask

  task automatic test_periods;
    int periods[3] = '{2, 4, 10};
    int c0, vn, vi, bb, exp; logic [7:0] res; logic ov;
    foreach (periods[k]) begin
      gen_mode = 1; half = periods[k] / 2; phase = $urandom_range(0, 99);
      settle(5);
      run_window(1'b0, 1'b0, c0, vn, vi, bb, res, ov);
      exp = sat(model_count(c0), W);
      tests_run++;
      if (res !== 8'(exp) || vn !== 1 || vi !== 102) begin
        tests_failed++;
        $display("FAIL period%0d: result=%0d valids=%0d at +%0d, expected %0d, 1 at +102",
                 periods[k], res, vn, vi, exp);
      end
      tests_run++;
      if (res !== 8'(GATE / periods[k])) begin
        tests_failed++;
        $display("FAIL period%0d_rate: got %0d expected %0d", periods[k], res, GATE / periods[k]);
      end
    end
  endtask

  task automatic test_random;
    int c0, vn, vi, bb, exp; logic [7:0] res; logic ov;
    for (int k = 0; k < 4; k++) begin
      gen_mode = 2;
      settle($urandom_range(4, 20));
      run_window(1'b0, 1'b0, c0, vn, vi, bb, res, ov);
      exp = sat(model_count(c0), W);
      tests_run++;
      if (res !== 8'(exp) || vn !== 1 || bb !== 0) begin
        tests_failed++;
        $display("FAIL random%0d: result=%0d valids=%0d busy_err=%0d, expected %0d 1 0",
                 k, res, vn, bb, exp);
      end
    end
  endtask

  task automatic test_saturation;
    int c0, vn, vi, bb, exp; logic [7:0] res; logic ov;
    gen_mode = 1; half = 1; phase = $urandom_range(0, 9);
    settle(5);
    run_window(1'b1, 1'b0, c0, vn, vi, bb, res, ov);
    exp = sat(model_count(c0), WS);
    tests_run++;
    if (res !== 8'(exp) || res !== 8'd31 || vi !== 102) begin
      tests_failed++;
      $display("FAIL sat_result: got %0d at +%0d expected %0d (31) at +102", res, vi, exp);
    end
`ifdef FREQ_METER_OVF_EN
    tests_run++;
    if (ov !== (model_count(c0) > 31)) begin
      tests_failed++;
      $display("FAIL sat_ovf: got %b expected %b", ov, model_count(c0) > 31);
    end
`endif
    half = 5;
    settle(5);
    run_window(1'b1, 1'b0, c0, vn, vi, bb, res, ov);
    exp = sat(model_count(c0), WS);
    tests_run++;
    if (res !== 8'(exp) || res !== 8'd10) begin
      tests_failed++;
      $display("FAIL sat_recover: got %0d expected %0d (10)", res, exp);
    end
`ifdef FREQ_METER_OVF_EN
    tests_run++;
    if (ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_ovf_clear: got %b expected 0", ov);
    end
`endif
  endtask

  task automatic test_extra_starts;
    int c0, vn, vi, bb, exp; logic [7:0] res; logic ov;
    gen_mode = 1; half = 2; phase = $urandom_range(0, 9);
    settle(5);
    run_window(1'b0, 1'b1, c0, vn, vi, bb, res, ov);
    exp = sat(model_count(c0), W);
    tests_run++;
    if (vn !== 1 || vi !== 102 || bb !== 0) begin
      tests_failed++;
      $display("FAIL extra_starts: valids=%0d last at +%0d busy_err=%0d, expected 1 at +102, 0",
               vn, vi, bb);
    end
    tests_run++;
    if (res !== 8'(exp)) begin
      tests_failed++;
      $display("FAIL extra_starts_result: got %0d expected %0d", res, exp);
    end
  endtask

  task automatic test_back_to_back;
    int c0, exp0, exp1;
    int vidx[$];
    logic [7:0] vres[$];
    gen_mode = 2;
    settle(5);
    @(negedge clk);
    c0 = cyc;
    bus_m.start = 1'b1;
    for (int i = 1; i <= 215; i++) begin
      @(negedge clk);
      if (i == 205) bus_m.start = 1'b0;
      if (bus_m.valid === 1'b1) begin
        vidx.push_back(i);
        vres.push_back(bus_m.result);
      end
    end
    exp0 = sat(model_count(c0), W);
    exp1 = sat(model_count(c0 + 103), W);
    tests_run++;
    if (vidx.size() !== 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d valid pulses expected 2", vidx.size());
    end else begin
      tests_run++;
      if (vidx[0] !== 102 || vidx[1] !== 205) begin
        tests_failed++;
        $display("FAIL b2b_timing: pulses at +%0d,+%0d expected +102,+205", vidx[0], vidx[1]);
      end
      tests_run++;
      if (vres[0] !== 8'(exp0) || vres[1] !== 8'(exp1)) begin
        tests_failed++;
        $display("FAIL b2b_result: got %0d,%0d expected %0d,%0d", vres[0], vres[1], exp0, exp1);
      end
    end
  endtask

  task automatic test_reset_mid;
    int c0, vn, vi, bb, exp, stray; logic [7:0] res; logic ov;
    gen_mode = 1; half = 5; phase = 0;
    settle(5);
    @(negedge clk);
    bus_m.start = 1'b1;
    stray = 0;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      bus_m.start = 1'b0;
      if (i == 60) rstn = 1'b0;
      if (i == 61) begin
        rstn = 1'b1;
        tests_run++;
        if (bus_m.busy !== 1'b0 || bus_m.result !== '0) begin
          tests_failed++;
          $display("FAIL mid_reset_state: busy=%b result=%0d expected 0 0",
                   bus_m.busy, bus_m.result);
        end
      end
      if (bus_m.valid === 1'b1) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_valid: got %0d pulses expected 0", stray);
    end
    run_window(1'b0, 1'b0, c0, vn, vi, bb, res, ov);
    exp = sat(model_count(c0), W);
    tests_run++;
    if (res !== 8'(exp) || vi !== 102 || vn !== 1) begin
      tests_failed++;
      $display("FAIL after_reset: result=%0d at +%0d (%0d pulses) expected %0d at +102 (1)",
               res, vi, vn, exp);
    end
  endtask

  initial begin
    bus_m.start = 1'b0;
    bus_s.start = 1'b0;
    test_reset();
    test_idle_zero();
    test_periods();
    test_random();
    test_saturation();
    test_extra_starts();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
